// File: rtl/ex_mem_skid_stage_if.sv
// rtl/ex_mem_skid_stage_if.sv - EX->MEM handshake and payload bundle (fwd_* present with EX_MEM_BYPASS_EN)
interface ex_mem_skid_stage_if #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32
);
  // EX side
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] rsd_addr_in;
  logic [DATA_W-1:0]     rsd_data_in;
  logic                  write_rsd_in;
  logic                  branch_in;
  logic [ADDR_W-1:0]     branch_addr_in;
  logic [ADDR_W-1:0]     mem_addr_in;
  logic                  mem_read_in;
  logic                  mem_write_in;

  // MEM side
  logic                  out_valid;
  logic                  out_ready;
  logic [REG_ADDR_W-1:0] rsd_addr_out;
  logic [DATA_W-1:0]     rsd_data_out;
  logic                  write_rsd_out;
  logic                  branch_out;
  logic [ADDR_W-1:0]     branch_addr_out;
  logic [ADDR_W-1:0]     mem_addr_out;
  logic                  mem_read_out;
  logic                  mem_write_out;

`ifdef EX_MEM_BYPASS_EN
  // operand forwarding back to EX
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0]     fwd_data;
`endif

  // the pipeline stage itself
  modport slave (
`ifdef EX_MEM_BYPASS_EN
    output fwd_valid, fwd_addr, fwd_data,
`endif
    input  in_valid, rsd_addr_in, rsd_data_in, write_rsd_in, branch_in,
           branch_addr_in, mem_addr_in, mem_read_in, mem_write_in,
    output in_ready,
    output out_valid, rsd_addr_out, rsd_data_out, write_rsd_out, branch_out,
           branch_addr_out, mem_addr_out, mem_read_out, mem_write_out,
    input  out_ready
  );

  // the surroundings driving the stage
  modport master (
`ifdef EX_MEM_BYPASS_EN
    input  fwd_valid, fwd_addr, fwd_data,
`endif
    output in_valid, rsd_addr_in, rsd_data_in, write_rsd_in, branch_in,
           branch_addr_in, mem_addr_in, mem_read_in, mem_write_in,
    input  in_ready,
    input  out_valid, rsd_addr_out, rsd_data_out, write_rsd_out, branch_out,
           branch_addr_out, mem_addr_out, mem_read_out, mem_write_out,
    output out_ready
  );
endinterface

// File: rtl/ex_mem_skid_stage.sv
// rtl/ex_mem_skid_stage.sv - EX/MEM register with 2-entry skid buffer, flush and x0 suppression; EX_MEM_BYPASS_EN adds forwarding outputs
module ex_mem_skid_stage #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   flush_in,
  ex_mem_skid_stage_if.slave     bus
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rsd_addr;
    logic [DATA_W-1:0]     rsd_data;
    logic                  write_rsd;
    logic                  branch;
    logic [ADDR_W-1:0]     branch_addr;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_read;
    logic                  mem_write;
  } entry_t;

  // EMPTY: nothing held; HALF: main valid; FULL: main and skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    MAIN_HOLD,
    MAIN_LOAD_IN,
    MAIN_LOAD_SKID,
    MAIN_CLEAR
  } main_op_t;

  state_t   state_q, state_next;
  main_op_t main_op;
  logic     skid_load, skid_clear;
  entry_t   main_q, skid_q, in_entry;
  logic     out_valid_q, in_ready_q;
  logic     accept, consume;

  // handshake flags decode straight from the state flops, so ready never sees out_ready
  assign out_valid_q = (state_q != EMPTY);
  assign in_ready_q  = (state_q != FULL);

  assign accept  = bus.in_valid & in_ready_q;
  assign consume = out_valid_q & bus.out_ready;

  // writes to x0 are dropped here so MEM/WB never have to look at the index
  assign in_entry.rsd_addr    = bus.rsd_addr_in;
  assign in_entry.rsd_data    = bus.rsd_data_in;
  assign in_entry.write_rsd   = bus.write_rsd_in & (bus.rsd_addr_in != '0);
  assign in_entry.branch      = bus.branch_in;
  assign in_entry.branch_addr = bus.branch_addr_in;
  assign in_entry.mem_addr    = bus.mem_addr_in;
  assign in_entry.mem_read    = bus.mem_read_in;
  assign in_entry.mem_write   = bus.mem_write_in;

  // state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= EMPTY;
    else        state_q <= state_next;
  end

  // next state and datapath steering; flush overrides every handshake
  always_comb begin
    state_next = state_q;
    main_op    = MAIN_HOLD;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush_in) begin
      state_next = EMPTY;
      main_op    = MAIN_CLEAR;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_next = HALF;
            main_op    = MAIN_LOAD_IN;
          end
        end
        HALF: begin
          if (accept && consume) begin
            main_op    = MAIN_LOAD_IN;
          end else if (accept) begin
            state_next = FULL;
            skid_load  = 1'b1;
          end else if (consume) begin
            state_next = EMPTY;
            main_op    = MAIN_CLEAR;
          end
        end
        FULL: begin
          if (consume) begin
            state_next = HALF;
            main_op    = MAIN_LOAD_SKID;
            skid_clear = 1'b1;
          end
        end
        default: begin
          state_next = EMPTY;
          main_op    = MAIN_CLEAR;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // payload registers; empty slots are kept at zero
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (main_op)
        MAIN_LOAD_IN:   main_q <= in_entry;
        MAIN_LOAD_SKID: main_q <= skid_q;
        MAIN_CLEAR:     main_q <= '0;
        default:        main_q <= main_q;
      endcase
      if (skid_clear)     skid_q <= '0;
      else if (skid_load) skid_q <= in_entry;
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.rsd_addr_out    = main_q.rsd_addr;
  assign bus.rsd_data_out    = main_q.rsd_data;
  assign bus.write_rsd_out   = main_q.write_rsd;
  assign bus.branch_out      = main_q.branch;
  assign bus.branch_addr_out = main_q.branch_addr;
  assign bus.mem_addr_out    = main_q.mem_addr;
  assign bus.mem_read_out    = main_q.mem_read;
  assign bus.mem_write_out   = main_q.mem_write;

`ifdef EX_MEM_BYPASS_EN
  // a load's result is not known until MEM finishes, so it cannot be forwarded yet
  assign bus.fwd_valid = out_valid_q & main_q.write_rsd & ~main_q.mem_read;
  assign bus.fwd_addr  = main_q.rsd_addr;
  assign bus.fwd_data  = main_q.rsd_data;
`endif

endmodule
